// File: rtl/vi_pkg.sv
// Shared constants and helpers for the frame-marker generator family.
package vi_pkg;

  localparam logic [1:0] VI_MODE_PASS  = 2'd0;
  localparam logic [1:0] VI_MODE_BLANK = 2'd1;
  localparam logic [1:0] VI_MODE_FILL  = 2'd2;
  localparam logic [1:0] VI_MODE_MARK  = 2'd3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned vi_cw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, plus rise/fall strobes
// derived from the synchronised level and its one-clock delayed copy.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Shift the async level through the chain; delay the synchronised copy once.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and delay registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];
  assign o_rise = o_sync & ~dly_q;
  assign o_fall = ~o_sync & dly_q;

endmodule

// File: rtl/vi_frame_gen.sv
// Frame-marker generator: counts reference pulses into frames, re-emits the
// pulse train with a frame-boundary gap pattern, and flags reference loss.
module vi_frame_gen
  import vi_pkg::*;
#(
  parameter int unsigned PERIOD      = 40,
  parameter int unsigned GAP_POS     = 39,
  parameter int unsigned GAP_LEN     = 1,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ref,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      resync,
  output logic                      o_vi,
  output logic                      o_frame,
  output logic [vi_cw(PERIOD)-1:0]  o_idx,
  output logic                      o_lost
);

  localparam int unsigned CW = vi_cw(PERIOD);
  localparam int unsigned TW = vi_cw(TIMEOUT + 1);

  localparam logic [CW-1:0] IDX_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] GAP_FIRST = CW'(GAP_POS);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_POS + GAP_LEN - 1);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);

  if (PERIOD < 2) begin : g_chk_period
    $error("vi_frame_gen: PERIOD must be at least 2");
  end
  if (GAP_LEN < 1) begin : g_chk_gap_len
    $error("vi_frame_gen: GAP_LEN must be at least 1");
  end
  if (GAP_POS + GAP_LEN > PERIOD) begin : g_chk_gap_fit
    $error("vi_frame_gen: gap window does not fit inside the frame");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("vi_frame_gen: TIMEOUT must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("vi_frame_gen: SYNC_STAGES must be at least 2");
  end

  logic          ref_s, ref_rise, ref_fall;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          frame_q, frame_d;
  logic          vi_q, vi_d;
  logic          lost_q, lost_d;
  logic          hold_out, in_gap;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_ref),
    .o_sync  (ref_s),
    .o_rise  (ref_rise),
    .o_fall  (ref_fall)
  );

  assign hold_out = lost_q | ~en;
  assign in_gap   = (idx_q >= GAP_FIRST) && (idx_q <= GAP_END);

  // Pulse index: parked on the last slot while held so the next fall opens a frame.
  always_comb begin
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (resync || hold_out) begin
      idx_d = IDX_LAST;
    end else if (ref_fall) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        frame_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Edge-free clock counter; lost is registered from the next count so it
  // tracks the counter exactly, dropping the clock after an edge is seen.
  always_comb begin
    if (ref_rise || ref_fall) begin
      tcnt_d = '0;
    end else if (tcnt_q == TMAX) begin
      tcnt_d = TMAX;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
    lost_d = (tcnt_d == TMAX);
  end

  // Output pulse shaping by mode; forced low while lost or disabled.
  always_comb begin
    vi_d = 1'b0;
    if (!hold_out) begin
      case (mode)
        VI_MODE_PASS:  vi_d = ref_s;
        VI_MODE_BLANK: vi_d = ref_s & ~in_gap;
        VI_MODE_FILL:  vi_d = ref_s | in_gap;
        default:       vi_d = ref_s & (idx_q == '0);
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= IDX_LAST;
      tcnt_q  <= TMAX;
      frame_q <= 1'b0;
      vi_q    <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      frame_q <= frame_d;
      vi_q    <= vi_d;
      lost_q  <= lost_d;
    end
  end

  assign o_vi    = vi_q;
  assign o_frame = frame_q;
  assign o_idx   = idx_q;
  assign o_lost  = lost_q;

endmodule

// File: tb/tb_vi_frame_gen.sv
// Scoreboard bench for vi_frame_gen: a default instance and a short-frame
// instance share the stimulus; expected output pulses/frames are queued per
// reference pulse and checked by a negedge monitor.
module tb_vi_frame_gen;
  import vi_pkg::*;

  localparam int H = 50;  // reference high phase, clocks
  localparam int L = 50;  // reference low phase, clocks
  localparam int T = H + L;
  localparam int PA = 40, GPA = 39, GLA = 1;
  localparam int PB = 8,  GPB = 5,  GLB = 2;

  localparam int ACT_NONE = 0, ACT_RS_MID = 1, ACT_RS_FALL = 2, ACT_RST_MID = 3, ACT_STOP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_ref = 1'b0;
  logic       en = 1'b1;
  logic       resync = 1'b0;
  logic [1:0] mode = VI_MODE_BLANK;

  logic       oa_vi, oa_frame, oa_lost;
  logic [5:0] oa_idx;
  logic       ob_vi, ob_frame, ob_lost;
  logic [2:0] ob_idx;

  vi_frame_gen #(
    .PERIOD (PA), .GAP_POS (GPA), .GAP_LEN (GLA), .TIMEOUT (255), .SYNC_STAGES (2)
  ) u_a (
    .clk (clk), .rst (rst), .i_ref (i_ref), .en (en), .mode (mode), .resync (resync),
    .o_vi (oa_vi), .o_frame (oa_frame), .o_idx (oa_idx), .o_lost (oa_lost)
  );

  vi_frame_gen #(
    .PERIOD (PB), .GAP_POS (GPB), .GAP_LEN (GLB), .TIMEOUT (255), .SYNC_STAGES (2)
  ) u_b (
    .clk (clk), .rst (rst), .i_ref (i_ref), .en (en), .mode (mode), .resync (resync),
    .o_vi (ob_vi), .o_frame (ob_frame), .o_idx (ob_idx), .o_lost (ob_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_frame;
    int idx;
    int width;  // 0 = width not checked
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  e_idx[2];
  bit  mon_en = 1'b0;
  bit  pv[2];
  int  wc[2];
  int  we[2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic ev_t mk(input bit f, input int i, input int w);
    ev_t e;
    e.is_frame = f;
    e.idx      = i;
    e.width    = w;
    return e;
  endfunction

  function automatic void push(input int n, input ev_t e);
    if (n == 0) qa.push_back(e);
    else        qb.push_back(e);
  endfunction

  function automatic int qsize(input int n);
    return (n == 0) ? qa.size() : qb.size();
  endfunction

  function automatic ev_t pop(input int n);
    if (n == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  // Expected response of instance n to one reference pulse.
  task automatic model_pulse(input int n, input bit active, input bit lost_rel,
                             input bit adv, input bit park_after);
    int p, gp, gl, idx, w;
    bit in_gap;
    p   = (n == 0) ? PA : PB;
    gp  = (n == 0) ? GPA : GPB;
    gl  = (n == 0) ? GLA : GLB;
    idx = e_idx[n];
    w   = lost_rel ? H - 1 : H;  // o_vi starts one clock late when lost clears mid-pulse
    if (active) begin
      in_gap = (idx >= gp) && (idx <= gp + gl - 1);
      case (mode)
        VI_MODE_PASS:  push(n, mk(1'b0, idx, w));
        VI_MODE_BLANK: if (!in_gap) push(n, mk(1'b0, idx, w));
        VI_MODE_FILL:  if (!in_gap) push(n, mk(1'b0, idx, w));
        default:       if (idx == 0) push(n, mk(1'b0, idx, w));
      endcase
      if (adv) begin
        idx = (idx == p - 1) ? 0 : idx + 1;
        if (idx == 0) push(n, mk(1'b1, 0, 0));
        // Fill slot rises two clocks after the fall that enters the gap and
        // stays high for the whole gap, i.e. gl reference periods.
        if (mode == VI_MODE_FILL && idx == gp) push(n, mk(1'b0, gp, gl * T));
      end
    end
    if (!active || !adv || park_after) idx = p - 1;
    e_idx[n] = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int act, input bit lat_chk, input bit lost_rel);
    int nlow;
    bit park;
    park = (act == ACT_RS_MID) || (act == ACT_RST_MID) || (act == ACT_STOP);
    model_pulse(0, en, lost_rel, act != ACT_RS_FALL, park);
    model_pulse(1, en, lost_rel, act != ACT_RS_FALL, park);
    nlow = (act == ACT_STOP) ? 300 : L;
    i_ref = 1'b1;
    for (int i = 1; i <= H; i++) begin
      tick();
      if (lat_chk && i == 2) check("vi_latency_pre", oa_vi, 0);
      if (lat_chk && i == 3) check("vi_latency_3clk", oa_vi, 1);
      if (lost_rel && i == 2) check("lost_still_set_a", oa_lost, 1);
      if (lost_rel && i == 3) begin
        check("lost_clear_a", oa_lost, 0);
        check("lost_clear_b", ob_lost, 0);
      end
    end
    i_ref = 1'b0;
    for (int i = 1; i <= nlow; i++) begin
      tick();
      if (act == ACT_RS_FALL && i == 2) resync = 1'b1;
      if (act == ACT_RS_FALL && i == 3) begin
        resync = 1'b0;
        check("rs_fall_idx_a", oa_idx, PA - 1);
        check("rs_fall_idx_b", ob_idx, PB - 1);
        check("rs_fall_noframe_a", oa_frame, 0);
        check("rs_fall_noframe_b", ob_frame, 0);
      end
      if (act == ACT_RS_MID && i == 20) resync = 1'b1;
      if (act == ACT_RS_MID && i == 21) begin
        resync = 1'b0;
        check("rs_mid_idx_a", oa_idx, PA - 1);
        check("rs_mid_idx_b", ob_idx, PB - 1);
      end
      if (act == ACT_RST_MID && i == 20) rst = 1'b1;
      if (act == ACT_RST_MID && i == 21) begin
        rst = 1'b0;
        check("rst_mid_vi_a", oa_vi, 0);
        check("rst_mid_frame_a", oa_frame, 0);
        check("rst_mid_idx_a", oa_idx, PA - 1);
        check("rst_mid_lost_a", oa_lost, 1);
        check("rst_mid_idx_b", ob_idx, PB - 1);
        check("rst_mid_lost_b", ob_lost, 1);
      end
      if (act == ACT_STOP && i == 257) check("loss_not_yet_a", oa_lost, 0);
      if (act == ACT_STOP && i == 258) begin
        check("loss_set_a", oa_lost, 1);
        check("loss_set_b", ob_lost, 1);
      end
      if (act == ACT_STOP && i == 300) begin
        check("loss_vi_a", oa_vi, 0);
        check("loss_idx_a", oa_idx, PA - 1);
        check("loss_idx_b", ob_idx, PB - 1);
      end
    end
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) pulse(ACT_NONE, 1'b0, 1'b0);
  endtask

  task automatic to_idx(input int t);
    int guard;
    guard = 0;
    while (e_idx[0] != t && guard < 64) begin
      pulse(ACT_NONE, 1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic mon(input int n, input logic vi, input logic fr, input int idx);
    ev_t e;
    if (vi && !pv[n]) begin
      check(n == 0 ? "pulse_expected_a" : "pulse_expected_b", int'(qsize(n) > 0), 1);
      we[n] = 0;
      if (qsize(n) > 0) begin
        e = pop(n);
        check(n == 0 ? "pulse_kind_a" : "pulse_kind_b", int'(e.is_frame), 0);
        check(n == 0 ? "pulse_idx_a" : "pulse_idx_b", idx, e.idx);
        we[n] = e.width;
      end
      wc[n] = 1;
    end else if (vi) begin
      wc[n]++;
    end else if (pv[n] && we[n] != 0) begin
      check(n == 0 ? "pulse_width_a" : "pulse_width_b", wc[n], we[n]);
    end
    if (fr) begin
      check(n == 0 ? "frame_expected_a" : "frame_expected_b", int'(qsize(n) > 0), 1);
      if (qsize(n) > 0) begin
        e = pop(n);
        check(n == 0 ? "frame_kind_a" : "frame_kind_b", int'(e.is_frame), 1);
      end
      check(n == 0 ? "frame_idx_a" : "frame_idx_b", idx, 0);
    end
    pv[n] = vi;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, oa_vi, oa_frame, int'(oa_idx));
      mon(1, ob_vi, ob_frame, int'(ob_idx));
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("reset_vi_a", oa_vi, 0);
    check("reset_frame_a", oa_frame, 0);
    check("reset_idx_a", oa_idx, PA - 1);
    check("reset_lost_a", oa_lost, 1);
    check("reset_idx_b", ob_idx, PB - 1);
    check("reset_lost_b", ob_lost, 1);
    e_idx[0] = PA - 1;
    e_idx[1] = PB - 1;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    // Blank mode: first pulse clears lost, then two complete frames.
    mode = VI_MODE_BLANK;
    pulse(ACT_NONE, 1'b0, 1'b1);
    pulse(ACT_NONE, 1'b1, 1'b0);
    to_idx(0);
    pulses(40);

    mode = VI_MODE_FILL;
    pulses(40);
    mode = VI_MODE_MARK;
    pulses(40);
    mode = VI_MODE_PASS;
    pulses(40);
    mode = VI_MODE_BLANK;

    // Resync while idx is 17, then resync coincident with a wrapping fall.
    to_idx(16);
    pulse(ACT_RS_MID, 1'b0, 1'b0);
    pulse(ACT_NONE, 1'b0, 1'b0);
    to_idx(39);
    pulse(ACT_RS_FALL, 1'b0, 1'b0);
    pulse(ACT_NONE, 1'b0, 1'b0);

    // Generator disabled for a few pulses.
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse(ACT_NONE, 1'b0, 1'b0);
      check("dis_idx_a", oa_idx, PA - 1);
      check("dis_idx_b", ob_idx, PB - 1);
    end
    en = 1'b1;
    pulses(3);

    // Reference stops for 300 clocks, then resumes.
    to_idx(10);
    pulse(ACT_STOP, 1'b0, 1'b0);
    pulse(ACT_NONE, 1'b0, 1'b1);
    pulses(3);

    // Reset mid-frame at idx 22.
    to_idx(21);
    pulse(ACT_RST_MID, 1'b0, 1'b0);
    pulse(ACT_NONE, 1'b0, 1'b1);
    pulses(5);

    repeat (20) tick();
    check("queue_drained_a", qa.size(), 0);
    check("queue_drained_b", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vi_frame_gen.md
# vi_frame_gen

Parametrised frame-marker generator for the telemetry output path. It takes the reference square wave (320 kHz bit clock) and counts its pulses into frames of PERIOD pulses. It re-emits the pulse train with a configurable gap pattern that marks the frame boundary. It also provides a frame strobe, the current pulse index and a loss-of-reference flag for the downstream framer and the status logic.

## Interface
Parameters:
- PERIOD, 40: pulses per frame; ≥ 2.
- GAP_POS, 39: index of first gap pulse; GAP_POS + GAP_LEN ≤ PERIOD, checked at elaboration.
- GAP_LEN, 1: number of consecutive gap pulses; ≥ 1.
- TIMEOUT, 255: number of edge-free clocks before loss is declared; ≥ 2.
- SYNC_STAGES, 2: synchroniser depth for i_ref; ≥ 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- i_ref  in  1  reference square wave, asynchronous to clk.
- en  in  1  generator enable.
- mode  in  2  output mode, vi_pkg encoding.
- resync  in  1  one-cycle request to restart the frame.
- o_vi  out  1  gapped pulse output.
- o_frame  out  1  one-cycle strobe at each frame start.
- o_idx  out  CW  current pulse index, CW = $clog2(PERIOD).
- o_lost  out  1  reference lost.

## Operation
- **Edge detection.** i_ref passes through SYNC_STAGES flops to give ref_s; ref_d is ref_s delayed one clock. rise = ref_s & ~ref_d; fall = ~ref_s & ref_d.
- **Pulse counter (idx).**
  - On fall: idx = (idx == PERIOD−1) ? 0 : idx+1.
  - o_frame = 1 for one cycle when fall wraps idx to 0.
- **Gap window.** in_gap = (GAP_POS ≤ idx ≤ GAP_POS+GAP_LEN−1).
- **Modes (o_vi, registered every cycle):**
  - 0 PASS: o_vi = ref_s.
  - 1 BLANK: o_vi = ref_s & ~in_gap.
  - 2 FILL: o_vi = ref_s | in_gap; the gap slot is held high.
  - 3 MARK: o_vi = ref_s & (idx == 0); only the first pulse of each frame is output.
- **Loss detection.**
  - Edge-free counter tcnt (width $clog2(TIMEOUT+1)) clears on any rise or fall and otherwise increments, saturating at TIMEOUT.
  - o_lost = (tcnt == TIMEOUT), registered.
- **Hold states.** Any of o_lost = 1, en = 0, or resync = 1 gives:
  - idx forced to PERIOD−1;
  - o_vi = 0 and o_frame = 0 while o_lost or ~en.
  - The first fall after release therefore wraps idx to 0 and fires o_frame.
- **Priority:** rst > resync > (o_lost | ~en) > fall.
  - resync coincident with fall: idx = PERIOD−1, no o_frame.
- mode is sampled every cycle and has no internal re-timing. Software changes it only at frame boundaries.

## Timing
- **Reset values:** o_vi = 0, o_frame = 0, o_idx = PERIOD−1, o_lost = 1, tcnt = TIMEOUT, sync chain = 0.
  - rst asserted mid-frame: all outputs take their reset values on the next clock edge.
- **Latency:** i_ref edge to o_vi edge is SYNC_STAGES+1 clocks. fall detection to o_idx / o_frame update is 1 clock.
- **o_lost rise:** o_lost rises when tcnt reaches TIMEOUT, i.e. TIMEOUT clocks after the last detected edge, plus 1 register.
- **o_lost fall:** o_lost falls 1 clock after the first detected edge.
- **in_gap timing:** idx changes only on fall, while ref_s = 0. in_gap is therefore stable across every high phase and o_vi never glitches inside a pulse.
- **Minimum reference rate:** i_ref high and low phases must each be ≥ SYNC_STAGES+1 clocks.

## Structure
- **Package vi_pkg:**
  - mode constants VI_MODE_PASS = 2'd0, VI_MODE_BLANK = 2'd1, VI_MODE_FILL = 2'd2, VI_MODE_MARK = 2'd3;
  - width helper function for CW.
- **Sub-module sync_edge:** parametrised SYNC_STAGES synchroniser plus rise/fall detector. It is reused by other reference-driven blocks.
- **Top:** idx counter, timeout counter and output mux in vi_frame_gen.

## Test plan
- **Default frame.** Defaults, mode 1, clk = 100 × i_ref period, release rst.
  - o_lost falls after the first edge.
  - From the first frame on, each frame shows 39 pulses and pulse 39 is absent.
  - o_frame fires once per 40 falls.
  - o_vi lags i_ref by 3 clocks.
- **Fill mode.** Mode 2: o_vi is continuously high through the whole pulse-39 slot; all other pulses are unchanged.
- **Loss and recovery.**
  - Stop i_ref for 300 clocks: o_lost = 1 exactly 256 clocks after the last edge, o_vi = 0, o_idx = 39.
  - Restart i_ref: o_lost = 0; the first fall gives o_frame = 1 and o_idx = 0.
- **Resync.**
  - resync at idx = 17: o_idx = 39, and the next fall starts a frame.
  - resync coincident with a fall: no o_frame, o_idx = 39.
- **Custom parameters.** PERIOD = 8, GAP_POS = 5, GAP_LEN = 2.
  - Mode 1: pulses 5 and 6 are blanked.
  - Mode 3: only pulse 0 appears.
  - Mode 0: all 8 pulses appear.
- **Reset and enable.**
  - rst asserted mid-frame (idx = 22): all outputs at reset values 1 clock later.
  - en = 0: o_vi = 0, o_frame = 0, o_idx = 39 held.
